dbus_ram: RTL and testbench

- DBus responder: single-port word RAM that terminates the core's data bus.
- Sits on the memory side of the DBus opposite the load/store unit; returns dbus_rd_data, dbus_wait and dbus_err.
- Performs byte-lane alignment, since the initiator presents LSB-justified data and strobes.
- Adds configurable wait states, address-range decode and misalignment error reporting.

---
 rtl/dbus_ram_pkg.sv | 16 +
 rtl/dbus_ram_if.sv | 24 ++
 rtl/dbus_lane_align.sv | 31 +++
 rtl/dbus_ram.sv | 190 +++++++++++++++++++
 tb/tb_dbus_ram.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dbus_ram_pkg.sv
// dbus_ram_pkg: shared types for the DBus RAM responder.
// FSM state encoding and DBus lane-strobe encodings.
package dbus_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    CLEAR
  } dbus_ram_state_t;

  localparam logic [3:0] DBUS_STROBE_B = 4'h1;
  localparam logic [3:0] DBUS_STROBE_H = 4'h3;
  localparam logic [3:0] DBUS_STROBE_W = 4'hF;

endpackage

// File: rtl/dbus_ram_if.sv
// dbus_ram_if: core data bus between load/store unit and memory.
// master = initiator (LSU), slave = responder (RAM).
interface dbus_ram_if;
  logic        dbus_rd_en;
  logic        dbus_wr_en;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wr_data;
  logic [3:0]  dbus_wr_strobe;
  logic [31:0] dbus_rd_data;
  logic        dbus_wait;
  logic        dbus_err;

  modport master (
    output dbus_rd_en, dbus_wr_en, dbus_addr,
    output dbus_wr_data, dbus_wr_strobe,
    input  dbus_rd_data, dbus_wait, dbus_err
  );

  modport slave (
    input  dbus_rd_en, dbus_wr_en, dbus_addr,
    input  dbus_wr_data, dbus_wr_strobe,
    output dbus_rd_data, dbus_wait, dbus_err
  );
endinterface

// File: rtl/dbus_lane_align.sv
// dbus_lane_align: moves LSB-justified bus data/strobes onto byte lanes.
// In: offset, strobe, wr_data, rd_word. Out: lane_mask, shifts, misalign.
module dbus_lane_align
  import dbus_ram_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [3:0]  strobe,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  lane_mask,
  output logic [31:0] wr_shift,
  output logic [31:0] rd_shift,
  output logic        misalign
);

  assign lane_mask = 4'(strobe << offset);
  assign wr_shift  = wr_data << {offset, 3'b000};
  assign rd_shift  = rd_word >> {offset, 3'b000};

  // Unknown strobe patterns are treated as misaligned (rejected).
  always_comb begin
    misalign = 1'b1;
    unique case (1'b1)
      strobe == DBUS_STROBE_B: misalign = 1'b0;
      strobe == DBUS_STROBE_H: misalign = offset[0];
      strobe == DBUS_STROBE_W: misalign = |offset;
      default:                 misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dbus_ram.sv
// dbus_ram: DBus responder word RAM with wait states and error decode.
// Ports: clk, rst (async high), bus (dbus_ram_if.slave).
// Option DBUS_RAM_ZERO_INIT_EN: zero all words after reset release.
module dbus_ram
  import dbus_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic      clk,
  input  logic      rst,
  dbus_ram_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  dbus_ram_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [3:0]    strb_q, strb_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          wr_q, wr_d;
  logic [31:0]   rword_q;
  logic [31:0]   mem [DEPTH];
`ifdef DBUS_RAM_ZERO_INIT_EN
  localparam logic [AW-1:0] IDX_MAX = AW'(DEPTH - 1);
  logic [AW-1:0] clr_q, clr_d;
`endif

  logic [31:0]   rel;
  logic [AW-1:0] idx_live;
  logic          req, bad, live;
  logic [1:0]    a_off;
  logic [3:0]    a_strb;
  logic [31:0]   a_wdat;
  logic [3:0]    lane;
  logic [31:0]   wr_sh, rd_sh;
  logic          misal;
  logic          we, re;
  logic [AW-1:0] m_idx;
  logic [3:0]    m_mask;
  logic [31:0]   m_data;
  logic          wait_o, err_o;
  logic [31:0]   rdat_o;

  // Base is aligned, so rel[1:0] equals the byte offset; below-base
  // addresses wrap to large values and fail the span compare.
  assign rel      = bus.dbus_addr - BASE_ADDR;
  assign idx_live = rel[AW+1:2];
  assign req      = bus.dbus_rd_en | bus.dbus_wr_en;
  assign live     = (state_q == IDLE);

  // Live bus in IDLE, latched copy once the access is in flight.
  assign a_off  = live ? bus.dbus_addr[1:0]   : off_q;
  assign a_strb = live ? bus.dbus_wr_strobe   : strb_q;
  assign a_wdat = live ? bus.dbus_wr_data     : wdat_q;

  dbus_lane_align u_align (
    .offset    (a_off),
    .strobe    (a_strb),
    .wr_data   (a_wdat),
    .rd_word   (rword_q),
    .lane_mask (lane),
    .wr_shift  (wr_sh),
    .rd_shift  (rd_sh),
    .misalign  (misal)
  );

  assign bad = (bus.dbus_rd_en & bus.dbus_wr_en)
             | (rel >= SPAN)
             | (bus.dbus_wr_en & misal);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    strb_d  = strb_q;
    wdat_d  = wdat_q;
    wr_d    = wr_q;
`ifdef DBUS_RAM_ZERO_INIT_EN
    clr_d   = clr_q;
`endif
    we      = 1'b0;
    re      = 1'b0;
    m_idx   = idx_q;
    m_mask  = lane;
    m_data  = wr_sh;
    wait_o  = 1'b0;
    err_o   = 1'b0;
    rdat_o  = '0;
    case (state_q)
      IDLE: begin
        if (req && bad) begin
          err_o = 1'b1;
        end else if (req) begin
          idx_d  = idx_live;
          off_d  = bus.dbus_addr[1:0];
          strb_d = bus.dbus_wr_strobe;
          wdat_d = bus.dbus_wr_data;
          wr_d   = bus.dbus_wr_en;
          m_idx  = idx_live;
          if (bus.dbus_wr_en) begin
            if (WS == 4'd0) begin
              we = 1'b1;
            end else begin
              wait_o  = 1'b1;
              cnt_d   = WS - 4'd1;
              state_d = (WS == 4'd1) ? DONE : WAIT;
            end
          end else begin
            re      = 1'b1;
            wait_o  = 1'b1;
            cnt_d   = WS;
            state_d = (WS == 4'd0) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        wait_o = 1'b1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        if (wr_q) we = 1'b1;
        else      rdat_o = rd_sh;
        state_d = IDLE;
      end
`ifdef DBUS_RAM_ZERO_INIT_EN
      CLEAR: begin
        wait_o = 1'b1;
        we     = 1'b1;
        m_idx  = clr_q;
        m_mask = 4'hF;
        m_data = '0;
        clr_d  = clr_q + 1'b1;
        if (clr_q == IDX_MAX) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef DBUS_RAM_ZERO_INIT_EN
      state_q <= CLEAR;
      clr_q   <= '0;
`else
      state_q <= IDLE;
`endif
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      strb_q  <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef DBUS_RAM_ZERO_INIT_EN
      clr_q   <= clr_d;
`endif
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      strb_q  <= strb_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
    end
  end

  // Storage has no reset; rst blocks any commit at a reset edge.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (m_mask[b]) mem[m_idx][8*b +: 8] <= m_data[8*b +: 8];
      end
    end
    if (re && !rst) rword_q <= mem[m_idx];
  end

  assign bus.dbus_wait    = wait_o & ~rst;
  assign bus.dbus_err     = err_o & ~rst;
  assign bus.dbus_rd_data = rst ? 32'h0 : rdat_o;

endmodule

// File: tb/tb_dbus_ram.sv
// tb_dbus_ram: scoreboard bench for dbus_ram, two instances
// (0 and 3 wait states, 16 words); covers DBUS_RAM_ZERO_INIT_EN.
module tb_dbus_ram;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int DEPTH = 16;

  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [31:0] mdl [2][DEPTH];

  dbus_ram_if b0 ();
  dbus_ram_if b3 ();

  dbus_ram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  dbus_ram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st);
    if (s == 0) begin
      b0.dbus_rd_en = rd;
      b0.dbus_wr_en = wr;
      b0.dbus_addr = a;
      b0.dbus_wr_data = d;
      b0.dbus_wr_strobe = st;
    end else begin
      b3.dbus_rd_en = rd;
      b3.dbus_wr_en = wr;
      b3.dbus_addr = a;
      b3.dbus_wr_data = d;
      b3.dbus_wr_strobe = st;
    end
  endtask

  task automatic smp(input int s, output logic wt, output logic er,
                     output logic [31:0] rv);
    if (s == 0) begin
      wt = b0.dbus_wait;
      er = b0.dbus_err;
      rv = b0.dbus_rd_data;
    end else begin
      wt = b3.dbus_wait;
      er = b3.dbus_err;
      rv = b3.dbus_rd_data;
    end
  endtask

  // Called at posedge+1. xw adds wait cycles expected before acceptance.
  task automatic do_acc(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, input logic e,
                        input int xw);
    exp_t x;
    exp_t y;
    int n;
    int nz;
    int ws;
    logic wt;
    logic er;
    logic [31:0] rv;
    logic [31:0] idx;
    logic [31:0] ln;
    logic [31:0] sh;
    ws = (s == 0) ? 0 : 3;
    idx = (a - BASE) >> 2;
    x.err = e;
    x.waits = e ? 0 : ((rd ? ws + 1 : ws) + xw);
    x.data = 32'h0;
    if (!e && rd) x.data = mdl[s][idx[3:0]] >> (8 * a[1:0]);
    if (!e && wr) begin
      ln = 32'(st) << a[1:0];
      sh = d << (8 * a[1:0]);
      for (int b = 0; b < 4; b++)
        if (ln[b]) mdl[s][idx[3:0]][8*b +: 8] = sh[8*b +: 8];
    end
    sb.push_back(x);
    drive(s, rd, wr, a, d, st);
    n = 0;
    nz = 0;
    forever begin
      @(negedge clk);
      smp(s, wt, er, rv);
      if (!wt) break;
      if (rv != 32'h0) nz++;
      n++;
      if (n > 64) break;
    end
    y = sb.pop_front();
    chk("waits", n, y.waits);
    chk("err", {31'h0, er}, {31'h0, y.err});
    chk("rdata", rv, y.data);
    chk("rd_zero_while_wait", nz, 0);
    @(posedge clk);
    #1;
    drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic zero_mdl();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[0][i] = 32'h0;
      mdl[1][i] = 32'h0;
    end
  endtask

  initial begin
    logic wt;
    logic er;
    logic [31:0] rv;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    zero_mdl();
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b1, BASE + 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    smp(0, wt, er, rv);
    chk("rst_err", {31'h0, er}, 32'h0);
    chk("rst_wait", {31'h0, wt}, 32'h0);
    chk("rst_rdata", rv, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef DBUS_RAM_ZERO_INIT_EN
    do_acc(0, 1, 0, BASE + 32'h8, 0, 4'h0, 0, DEPTH);
`endif
    do_acc(0, 0, 1, BASE + 32'h8, 32'hDEADBEEF, 4'hF, 0, 0);
    do_acc(0, 1, 0, BASE + 32'h8, 0, 4'h0, 0, 0);
    do_acc(0, 0, 1, BASE + 32'h8, 32'h11223344, 4'hF, 0, 0);
    do_acc(0, 0, 1, BASE + 32'h9, 32'h000000AA, 4'h1, 0, 0);
    do_acc(0, 1, 0, BASE + 32'h8, 0, 4'h0, 0, 0);
    do_acc(0, 1, 0, BASE + 32'hA, 0, 4'h0, 0, 0);
    do_acc(0, 0, 1, BASE + 32'h0, 32'hCAFEF00D, 4'hF, 0, 0);
    do_acc(0, 0, 1, BASE + 32'h1, 32'h00005555, 4'h3, 1, 0);
    do_acc(0, 1, 0, BASE + 32'h0, 0, 4'h0, 0, 0);
    do_acc(0, 1, 0, 32'h0000_FFFC, 0, 4'h0, 1, 0);
    do_acc(0, 1, 0, BASE + 32'h40, 0, 4'h0, 1, 0);
    do_acc(0, 1, 1, BASE + 32'h8, 0, 4'hF, 1, 0);
    do_acc(0, 0, 1, BASE + 32'h8, 32'h1, 4'h0, 1, 0);
    do_acc(0, 0, 1, BASE + 32'h8, 32'h5, 4'h5, 1, 0);
    do_acc(0, 0, 1, BASE + 32'hA, 32'h1, 4'hF, 1, 0);
    do_acc(0, 1, 0, BASE + 32'h8, 0, 4'h0, 0, 0);
    do_acc(0, 0, 1, BASE + 32'h4, 32'h0, 4'hF, 0, 0);
    do_acc(0, 0, 1, BASE + 32'h6, 32'h0000BEEF, 4'h3, 0, 0);
    do_acc(0, 0, 1, BASE + 32'h5, 32'h00000077, 4'h1, 0, 0);
    do_acc(0, 1, 0, BASE + 32'h4, 0, 4'h0, 0, 0);
    do_acc(0, 1, 0, BASE + 32'h7, 0, 4'h0, 0, 0);
    do_acc(1, 0, 1, BASE + 32'h10, 32'h0BADCAFE, 4'hF, 0, 0);
    do_acc(1, 1, 0, BASE + 32'h10, 0, 4'h0, 0, 0);
    do_acc(1, 0, 1, BASE + 32'h13, 32'h000000C3, 4'h1, 0, 0);
    do_acc(1, 1, 0, BASE + 32'h12, 0, 4'h0, 0, 0);
    do_acc(1, 0, 1, BASE + 32'h3C, 32'h99887766, 4'hF, 0, 0);
    do_acc(1, 1, 0, BASE + 32'h3F, 0, 4'h0, 0, 0);
    do_acc(1, 1, 0, BASE + 32'h40, 0, 4'h0, 1, 0);
    do_acc(1, 0, 1, BASE + 32'h12, 32'h1, 4'hF, 1, 0);
    // Abort a 3-wait-state write with reset while it sits in WAIT.
    drive(1, 1'b0, 1'b1, BASE + 32'h10, 32'h12345678, 4'hF);
    @(posedge clk);
    @(negedge clk);
    smp(1, wt, er, rv);
    chk("pre_rst_wait", {31'h0, wt}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    smp(1, wt, er, rv);
    chk("mid_rst_wait", {31'h0, wt}, 32'h0);
    chk("mid_rst_err", {31'h0, er}, 32'h0);
    chk("mid_rst_rdata", rv, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
`ifdef DBUS_RAM_ZERO_INIT_EN
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    zero_mdl();
`endif
    do_acc(1, 1, 0, BASE + 32'h10, 0, 4'h0, 0, 0);
    do_acc(0, 1, 0, BASE + 32'h8, 0, 4'h0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
